mul4_fitness_evaluator: RTL and testbench



---
 rtl/mul4_eval_pkg.sv | 57 +++++
 rtl/mul4_popcount64.sv | 18 +
 rtl/mul4_fitness_evaluator.sv | 137 +++++++++++++
 tb/tb_mul4_fitness_evaluator.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul4_eval_pkg.sv
// Shared constants, state encoding and bit-sliced helpers for the 2x2 multiplier
// fitness evaluator.
package mul4_eval_pkg;

  localparam int LANES      = 16;
  localparam int OUT_BITS   = 4;
  localparam int MATCH_BITS = LANES * OUT_BITS;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_DRIVE = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_SCORE = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  typedef struct packed {
    logic [15:0] a1;
    logic [15:0] a0;
    logic [15:0] b1;
    logic [15:0] b0;
  } stim_t;

  typedef struct packed {
    logic [15:0] y3;
    logic [15:0] y2;
    logic [15:0] y1;
    logic [15:0] y0;
  } prod_t;

  // Lane i carries a = i[3:2], b = i[1:0]: all 16 operand pairs in one vector set.
  localparam stim_t BASE_STIM = '{a1: 16'hFF00, a0: 16'hF0F0, b1: 16'hCCCC, b0: 16'hAAAA};

  function automatic prod_t golden_mul4(input logic [15:0] a1, input logic [15:0] a0,
                                        input logic [15:0] b1, input logic [15:0] b0);
    prod_t       p;
    logic [15:0] c1;
    p.y0 = a0 & b0;
    p.y1 = (a1 & b0) ^ (a0 & b1);
    c1   = a1 & b0 & a0 & b1;
    p.y2 = (a1 & b1) ^ c1;
    p.y3 = a1 & b1 & c1;
    return p;
  endfunction

  function automatic logic [15:0] rotl16(input logic [15:0] v, input logic [3:0] k);
    logic [31:0] d;
    d = {v, v} << k;
    return d[31:16];
  endfunction

  function automatic logic [15:0] rotr16(input logic [15:0] v, input logic [3:0] k);
    logic [31:0] d;
    d = {v, v} >> k;
    return d[15:0];
  endfunction

endpackage

// File: rtl/mul4_popcount64.sv
// Combinational population count of the 64 per-bit match flags.
module mul4_popcount64
  import mul4_eval_pkg::*;
(
  input  logic [MATCH_BITS-1:0] vec,
  output logic [6:0]            count
);

  // NOTE: default assignment before the loop keeps this block purely combinational (no latch).
  // An X/Z flag fails the if-test, so unknown candidate bits count as mismatches.
  always_comb begin
    count = '0;
    for (int i = 0; i < MATCH_BITS; i++) begin
      if (vec[i]) count = count + 7'd1;
    end
  end

endmodule

// File: rtl/mul4_fitness_evaluator.sv
// Drives rotated exhaustive stimulus into a 2x2 bit-sliced multiplier candidate and
// scores its outputs. Optional MUL4_EVAL_ERRMAP_EN adds the err_lanes base-lane error map.
module mul4_fitness_evaluator
  import mul4_eval_pkg::*;
#(
  parameter int ROUNDS   = 1,
  parameter int ROT_STEP = 4,
  parameter int CAND_LAT = 0,
  parameter int SCORE_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [15:0]        a1,
  output logic [15:0]        a0,
  output logic [15:0]        b1,
  output logic [15:0]        b0,
  input  logic [15:0]        y3,
  input  logic [15:0]        y2,
  input  logic [15:0]        y1,
  input  logic [15:0]        y0,
  output logic [SCORE_W-1:0] score,
  output logic               perfect
`ifdef MUL4_EVAL_ERRMAP_EN
  ,
  output logic [15:0]        err_lanes
`endif
);

  localparam int ROUND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int WAIT_W  = (CAND_LAT > 0) ? $clog2(CAND_LAT + 1) : 1;
  localparam logic [SCORE_W-1:0] FULL_SCORE = SCORE_W'(MATCH_BITS * ROUNDS);

  state_t                state_q;
  logic [ROUND_W-1:0]    round_q;
  logic [WAIT_W-1:0]     wait_q;
  logic [3:0]            rot_amt;
  prod_t                 expected;
  logic [MATCH_BITS-1:0] match;
  logic [6:0]            match_cnt;
  logic [SCORE_W:0]      sum_ext;
  logic [SCORE_W-1:0]    score_next;
  logic                  last_round;

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

  assign rot_amt  = 4'((int'(round_q) * ROT_STEP) % LANES);
  // Expectation follows the driven (rotated) vectors, so rotation never skews the score.
  assign expected = golden_mul4(a1, a0, b1, b0);
  assign match    = ~({y3, y2, y1, y0} ^ {expected.y3, expected.y2, expected.y1, expected.y0});

  mul4_popcount64 u_popcount (
    .vec  (match),
    .count(match_cnt)
  );

  assign sum_ext    = {1'b0, score} + {{(SCORE_W - 6){1'b0}}, match_cnt};
  assign score_next = sum_ext[SCORE_W] ? '1 : sum_ext[SCORE_W-1:0];
  assign last_round = (round_q == ROUND_W'(ROUNDS - 1));

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      wait_q  <= '0;
      score   <= '0;
      perfect <= 1'b0;
      a1      <= '0;
      a0      <= '0;
      b1      <= '0;
      b0      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            score   <= '0;
            perfect <= 1'b0;
            round_q <= '0;
            state_q <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          a1      <= rotl16(BASE_STIM.a1, rot_amt);
          a0      <= rotl16(BASE_STIM.a0, rot_amt);
          b1      <= rotl16(BASE_STIM.b1, rot_amt);
          b0      <= rotl16(BASE_STIM.b0, rot_amt);
          wait_q  <= WAIT_W'(CAND_LAT);
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_q == '0) state_q <= ST_SCORE;
          else              wait_q  <= wait_q - WAIT_W'(1);
        end
        ST_SCORE: begin
          score <= score_next;
          if (last_round) begin
            perfect <= (score_next == FULL_SCORE);
            state_q <= ST_DONE;
          end else begin
            round_q <= round_q + ROUND_W'(1);
            state_q <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          a1      <= '0;
          a0      <= '0;
          b1      <= '0;
          b0      <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef MUL4_EVAL_ERRMAP_EN
  logic [LANES-1:0] lane_bad;

  assign lane_bad = ~(match[63:48] & match[47:32] & match[31:16] & match[15:0]);

  // Driven lane j holds base lane j-rot, so rotating right maps failures back to base lanes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_lanes <= '0;
    end else if (state_q == ST_IDLE && start) begin
      err_lanes <= '0;
    end else if (state_q == ST_SCORE) begin
      err_lanes <= err_lanes | rotr16(lane_bad, rot_amt);
    end
  end
`endif

endmodule

// File: tb/tb_mul4_fitness_evaluator.sv
// Scoreboard bench: two evaluator instances (1 round combinational, 2 rounds latency 2)
// scored against a lane-level arithmetic reference model.
module tb_mul4_fitness_evaluator;

  localparam int STEP0   = 4;
  localparam int STEP1   = 5;
  localparam int LAT1    = 2;
  localparam int ROUNDS1 = 2;

  typedef struct {
    int          score;
    bit          perfect;
    logic [15:0] err;
    longint      cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic busy0, done0, perfect0, busy1, done1, perfect1;
  logic [15:0] a1_0, a0_0, b1_0, b0_0, a1_1, a0_1, b1_1, b0_1;
  logic [15:0] y3_0, y2_0, y1_0, y0_0, y3_1, y2_1, y1_1, y0_1;
  logic [15:0] score0, score1;
`ifdef MUL4_EVAL_ERRMAP_EN
  logic [15:0] err0, err1;
`endif

  bit          tie0 = 1'b0, tie1 = 1'b0;
  logic [15:0] tv0 = '0, tv1 = '0;
  logic [63:0] m0 = '0, m1 = '0;
  logic [63:0] pipe1 = '0, pipe2 = '0;

  exp_t   q0[$], q1[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Behavioural candidate: true lane products, optionally tied or with a fault mask.
  function automatic logic [63:0] cand_fn(logic [15:0] va1, logic [15:0] va0, logic [15:0] vb1,
                                          logic [15:0] vb0, bit tie, logic [15:0] tv,
                                          logic [63:0] m);
    logic [63:0] y;
    int a, b, p;
    y = '0;
    if (tie) return {tv, tv, tv, tv};
    for (int j = 0; j < 16; j++) begin
      a = 2 * int'(va1[j]) + int'(va0[j]);
      b = 2 * int'(vb1[j]) + int'(vb0[j]);
      p = a * b;
      y[48+j] = p[3];
      y[32+j] = p[2];
      y[16+j] = p[1];
      y[j]    = p[0];
    end
    return y ^ m;
  endfunction

  assign {y3_0, y2_0, y1_0, y0_0} = cand_fn(a1_0, a0_0, b1_0, b0_0, tie0, tv0, m0);

  always @(posedge clk) begin
    pipe1 <= cand_fn(a1_1, a0_1, b1_1, b0_1, tie1, tv1, m1);
    pipe2 <= pipe1;
  end
  assign {y3_1, y2_1, y1_1, y0_1} = pipe2;

  mul4_fitness_evaluator #(.ROUNDS(1), .ROT_STEP(STEP0), .CAND_LAT(0), .SCORE_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
    .a1(a1_0), .a0(a0_0), .b1(b1_0), .b0(b0_0),
    .y3(y3_0), .y2(y2_0), .y1(y1_0), .y0(y0_0),
    .score(score0), .perfect(perfect0)
`ifdef MUL4_EVAL_ERRMAP_EN
    , .err_lanes(err0)
`endif
  );

  mul4_fitness_evaluator #(.ROUNDS(ROUNDS1), .ROT_STEP(STEP1), .CAND_LAT(LAT1), .SCORE_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .a1(a1_1), .a0(a0_1), .b1(b1_1), .b0(b0_1),
    .y3(y3_1), .y2(y2_1), .y1(y1_1), .y0(y0_1),
    .score(score1), .perfect(perfect1)
`ifdef MUL4_EVAL_ERRMAP_EN
    , .err_lanes(err1)
`endif
  );

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: each base lane index k means a=k/4, b=k%4; round r puts base lane
  // (j - r*step) mod 16 on driven lane j.
  function automatic void model(input int rounds, input int step, input bit tie,
                                input logic [15:0] tv, input logic [63:0] m,
                                output int sc, output logic [15:0] err);
    int rot, base, p;
    logic [3:0] pn, out;
    sc  = 0;
    err = '0;
    for (int r = 0; r < rounds; r++) begin
      rot = (r * step) % 16;
      for (int j = 0; j < 16; j++) begin
        base = ((j - rot) % 16 + 16) % 16;
        p    = (base / 4) * (base % 4);
        pn   = p[3:0];
        out  = tie ? {tv[j], tv[j], tv[j], tv[j]} : (pn ^ {m[48+j], m[32+j], m[16+j], m[j]});
        for (int k = 0; k < 4; k++) if (out[k] == pn[k]) sc++;
        if (out != pn) err[base] = 1'b1;
      end
    end
  endfunction

  always @(negedge clk) begin : mon0
    exp_t e;
    if (done0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d0_spurious_done got done=1 expected no done");
      end else begin
        e = q0.pop_front();
        check("d0_done_cycle", 64'(cyc), 64'(e.cyc));
        check("d0_score", score0, 64'(e.score));
        check("d0_perfect", perfect0, e.perfect);
`ifdef MUL4_EVAL_ERRMAP_EN
        check("d0_err_lanes", err0, e.err);
`endif
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (done1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d1_spurious_done got done=1 expected no done");
      end else begin
        e = q1.pop_front();
        check("d1_done_cycle", 64'(cyc), 64'(e.cyc));
        check("d1_score", score1, 64'(e.score));
        check("d1_perfect", perfect1, e.perfect);
`ifdef MUL4_EVAL_ERRMAP_EN
        check("d1_err_lanes", err1, e.err);
`endif
      end
    end
  end

  task automatic wait_idle(int d);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 400 && !idle; i++) begin
      @(negedge clk);
      idle = d ? (q1.size() == 0 && !busy1) : (q0.size() == 0 && !busy0);
    end
    check(d ? "d1_complete" : "d0_complete", idle, 1);
  endtask

  task automatic run(int d, bit tie, logic [15:0] tv, logic [63:0] m, bit poke);
    exp_t e;
    int rounds, lat, step, n;
    rounds = d ? ROUNDS1 : 1;
    lat    = d ? LAT1 : 0;
    step   = d ? STEP1 : STEP0;
    n      = rounds * (lat + 3) + 1;
    model(rounds, step, tie, tv, m, e.score, e.err);
    e.perfect = (e.score == 64 * rounds);
    @(negedge clk);
    if (d) begin tie1 = tie; tv1 = tv; m1 = m; end
    else   begin tie0 = tie; tv0 = tv; m0 = m; end
    e.cyc = cyc + n;
    if (d) begin q1.push_back(e); start1 = 1'b1; end
    else   begin q0.push_back(e); start0 = 1'b1; end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    check(d ? "d1_busy_after_start" : "d0_busy_after_start", d ? busy1 : busy0, 1);
    if (poke && d) begin
      repeat (3) @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (n - 5) @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      check("d1_start_in_done_ignored", busy1, 0);
    end
    wait_idle(d);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    tie1 = 1'b0; m1 = '0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", busy1, 0);
    check("rst_mid_done", done1, 0);
    check("rst_mid_score", score1, 0);
    check("rst_mid_perfect", perfect1, 0);
    check("rst_mid_stim", {a1_1, a0_1, b1_1, b0_1}, 64'h0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_mid_no_resume", busy1, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy0", busy0, 0);
    check("rst_done0", done0, 0);
    check("rst_score0", score0, 0);
    check("rst_perfect0", perfect0, 0);
    check("rst_stim0", {a1_0, a0_0, b1_0, b0_0}, 64'h0);
    check("rst_busy1", busy1, 0);
    check("rst_stim1", {a1_1, a0_1, b1_1, b0_1}, 64'h0);
    rst_n = 1'b1;

    run(0, 1'b0, 16'h0000, 64'h0, 1'b0);
    run(0, 1'b1, 16'h0000, 64'h0, 1'b0);
    run(0, 1'b1, 16'hFFFF, 64'h0, 1'b0);
    run(0, 1'b0, 16'h0000, 64'h0000_0000_0000_FFFF, 1'b0);
    for (int i = 0; i < 6; i++) begin
      logic [63:0] m;
      m = {$urandom, $urandom};
      if (i % 2 == 0) m = m & {$urandom, $urandom} & {$urandom, $urandom};
      run(0, 1'b0, 16'h0000, m, 1'b0);
    end
    check("d0_stim_idle", {a1_0, a0_0, b1_0, b0_0}, 64'h0);

    run(1, 1'b0, 16'h0000, 64'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      logic [63:0] m;
      m = {$urandom, $urandom} & {$urandom, $urandom};
      run(1, 1'b0, 16'h0000, m, 1'b0);
    end
    run(1, 1'b1, 16'h0000, 64'h0, 1'b0);
    reset_mid();
    run(1, 1'b0, 16'h0000, 64'h0, 1'b0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
